// File: rtl/dmem_lat_pkg.sv
// Shared encodings for the latency data memory: access sizes, FSM states,
// counter width and the size-to-byte-count helper.
package dmem_lat_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lat_lane.sv
// Combinational access checker and load lane: flags misaligned or out-of-range
// accesses and extracts/extends load data from the raw 4-byte window.
module dmem_lat_lane
  import dmem_lat_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] window,
  output logic        err,
  output logic [31:0] load_data
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    out_of_range = (({1'b0, addr} + 33'(size_bytes(size))) > 33'(DEPTH));
    err          = misaligned || out_of_range;
  end

  always_comb begin
    load_data = window;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & window[7]}}, window[7:0]};
      SZ_HALF: load_data = {{16{~uns & window[15]}}, window[15:0]};
      default: load_data = window;
    endcase
  end

endmodule

// File: rtl/dmem_lat.sv
// Byte-addressable data memory with a configurable access latency, a valid/ready
// request port and a one-cycle response pulse carrying extended load data.
module dmem_lat
  import dmem_lat_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWE,
  input  logic [31:0] ReqAddr,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespErr
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] Mem [0:DEPTH-1];

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic [31:0]      cap_addr;
  logic [1:0]       cap_size;
  logic             cap_uns;
  logic [31:0]      cap_data;

  logic        accept;
  logic        complete;
  logic [31:0] window;
  logic        lane_err;
  logic [31:0] lane_data;

  // Handshake: a request transfers on a rising edge with ReqValid && ReqReady;
  // the requester holds its request until then, and ReqValid is ignored in WAIT.
  assign ReqReady = (state != ST_WAIT);
  assign accept   = ReqValid && ReqReady;
  assign complete = (state == ST_WAIT) && (cnt == '0);

  // Bytes past the end of Mem read as zero; such accesses are flagged anyway.
  always_comb begin
    window = '0;
    for (int i = 0; i < 4; i++) begin
      if (({1'b0, cap_addr} + 33'(i)) < 33'(DEPTH))
        window[8*i +: 8] = Mem[cap_addr[AW-1:0] + AW'(i)];
    end
  end

  dmem_lat_lane #(.DEPTH(DEPTH)) u_lane (
    .addr      (cap_addr),
    .size      (cap_size),
    .uns       (cap_uns),
    .window    (window),
    .err       (lane_err),
    .load_data (lane_data)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= SZ_BYTE;
      cap_uns   <= 1'b0;
      cap_data  <= '0;
      RespValid <= 1'b0;
      RespData  <= '0;
      RespErr   <= 1'b0;
    end else begin
      RespValid <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            cap_we   <= ReqWE;
            cap_addr <= ReqAddr;
            cap_size <= ReqSize;
            cap_uns  <= ReqUnsigned;
            cap_data <= ReqData;
            cnt      <= CNT_W'(LATENCY - 1);
            state    <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (complete) begin
            state     <= ST_RESP;
            RespValid <= 1'b1;
            RespErr   <= lane_err;
            RespData  <= (lane_err || cap_we) ? 32'h0 : lane_data;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset forces the FSM out of WAIT so no commit fires.
  always_ff @(posedge CLK) begin
    if (complete && cap_we && !lane_err) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < size_bytes(cap_size))
          Mem[cap_addr[AW-1:0] + AW'(i)] <= cap_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lat.sv
// Directed bench for dmem_lat: three instances at LATENCY 2, 3 and 1.
module tb_dmem_lat;
  import dmem_lat_pkg::*;

  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [1:0]  req_size   [3];
  logic        req_uns    [3];
  logic [31:0] req_data   [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_data  [3];
  logic        resp_err   [3];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_lat #(.DEPTH(DEPTH), .LATENCY(2)) u0 (
    .CLK(CLK), .RST(RST), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWE(req_we[0]), .ReqAddr(req_addr[0]), .ReqSize(req_size[0]),
    .ReqUnsigned(req_uns[0]), .ReqData(req_data[0]), .RespValid(resp_valid[0]),
    .RespData(resp_data[0]), .RespErr(resp_err[0]));

  dmem_lat #(.DEPTH(DEPTH), .LATENCY(3)) u1 (
    .CLK(CLK), .RST(RST), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWE(req_we[1]), .ReqAddr(req_addr[1]), .ReqSize(req_size[1]),
    .ReqUnsigned(req_uns[1]), .ReqData(req_data[1]), .RespValid(resp_valid[1]),
    .RespData(resp_data[1]), .RespErr(resp_err[1]));

  dmem_lat #(.DEPTH(DEPTH), .LATENCY(1)) u2 (
    .CLK(CLK), .RST(RST), .ReqValid(req_valid[2]), .ReqReady(req_ready[2]),
    .ReqWE(req_we[2]), .ReqAddr(req_addr[2]), .ReqSize(req_size[2]),
    .ReqUnsigned(req_uns[2]), .ReqData(req_data[2]), .RespValid(resp_valid[2]),
    .RespData(resp_data[2]), .RespErr(resp_err[2]));

  // Driver: present a request, wait for acceptance, then count negedges until RespValid.
  task automatic access(input int k, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] data,
                        output logic [31:0] rdata, output logic rerr, output int lat);
    int n;
    @(negedge CLK);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_size[k]  = size;
    req_uns[k]   = uns;
    req_data[k]  = data;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    @(negedge CLK);
    req_valid[k] = 1'b0;
    lat = 0;
    while (!resp_valid[k] && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    rdata = resp_data[k];
    rerr  = resp_err[k];
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_size[k] = SZ_BYTE; req_uns[k] = 1'b0; req_data[k] = '0;
    end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req_ready[k], resp_valid[k], resp_err[k], resp_data[k]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state inst %0d got rdy=%b vld=%b err=%b data=%h exp rdy=1 vld=0 err=0 data=0",
                 k, req_ready[k], resp_valid[k], resp_err[k], resp_data[k]);
      end
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int lat;
    access(0, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h0} || lat !== 2) begin
      errors++; $display("FAIL store_word got err=%b data=%h lat=%0d exp err=0 data=0 lat=2", e, d, lat);
    end
    checks++;
    if ({u0.Mem[10'h013], u0.Mem[10'h012], u0.Mem[10'h011], u0.Mem[10'h010]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_bytes got %h exp deadbeef",
        {u0.Mem[10'h013], u0.Mem[10'h012], u0.Mem[10'h011], u0.Mem[10'h010]});
    end
    access(0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hDEADBEEF} || lat !== 2) begin
      errors++; $display("FAIL load_word got err=%b data=%h lat=%0d exp err=0 data=deadbeef lat=2", e, d, lat);
    end
    @(negedge CLK);
    checks++;
    if (resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL resp_pulse_width got %b exp 0", resp_valid[0]);
    end
  endtask

  task automatic test_extend();
    logic [31:0] d; logic e; int lat;
    access(0, 1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFFFDE}) begin
      errors++; $display("FAIL byte_signed got %h exp ffffffde", d);
    end
    access(0, 1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h000000DE}) begin
      errors++; $display("FAIL byte_unsigned got %h exp 000000de", d);
    end
    access(0, 1'b0, 32'h12, SZ_HALF, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFDEAD}) begin
      errors++; $display("FAIL half_signed got %h exp ffffdead", d);
    end
    access(0, 1'b0, 32'h10, SZ_HALF, 1'b1, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h0000BEEF}) begin
      errors++; $display("FAIL half_unsigned got %h exp 0000beef", d);
    end
    access(0, 1'b0, 32'h11, SZ_BYTE, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFFFBE}) begin
      errors++; $display("FAIL byte_odd_signed got %h exp ffffffbe", d);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] d; logic e; int lat;
    access(0, 1'b1, 32'h30, SZ_WORD, 1'b0, 32'h12345678, d, e, lat);
    access(0, 1'b1, 32'h31, SZ_BYTE, 1'b0, 32'hFFFFFFA5, d, e, lat);
    access(0, 1'b1, 32'h32, SZ_HALF, 1'b0, 32'h9999BEEF, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL half_store_resp got err=%b data=%h exp err=0 data=0", e, d);
    end
    access(0, 1'b0, 32'h30, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hBEEFA578}) begin
      errors++; $display("FAIL partial_merge got %h exp beefa578", d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    access(0, 1'b1, 32'h11, SZ_HALF, 1'b0, 32'h00001234, d, e, lat);
    checks++;
    if ({e, d} !== {1'b1, 32'h0} || lat !== 2) begin
      errors++; $display("FAIL misaligned_half_store got err=%b data=%h lat=%0d exp err=1 data=0 lat=2", e, d, lat);
    end
    checks++;
    if ({u0.Mem[10'h012], u0.Mem[10'h011]} !== 16'hADBE) begin
      errors++; $display("FAIL misaligned_no_write got %h exp adbe", {u0.Mem[10'h012], u0.Mem[10'h011]});
    end
    access(0, 1'b0, DEPTH - 2, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL word_at_depth_minus_2 got err=%b data=%h exp err=1 data=0", e, d);
    end
    access(0, 1'b0, DEPTH, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL word_at_depth got err=%b data=%h exp err=1 data=0", e, d);
    end
    access(0, 1'b0, 32'hFFFFFFFF, SZ_BYTE, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL byte_no_wrap got err=%b data=%h exp err=1 data=0", e, d);
    end
    access(0, 1'b1, DEPTH - 1, SZ_BYTE, 1'b0, 32'h0000005A, d, e, lat);
    access(0, 1'b0, DEPTH - 1, SZ_BYTE, 1'b1, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h0000005A}) begin
      errors++; $display("FAIL last_byte got err=%b data=%h exp err=0 data=0000005a", e, d);
    end
    access(0, 1'b0, DEPTH - 4, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL last_word_in_range got err=%b exp 0", e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat;
    @(negedge CLK);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = SZ_WORD;
    req_uns[1] = 1'b0; req_addr[1] = 32'h40; req_data[1] = 32'hA0A00000;
    for (int t = 0; t < 17; t++) begin
      checks++;
      if (req_ready[1] !== (t % 4 == 0)) begin
        errors++; $display("FAIL b2b_ready t=%0d got %b exp %b", t, req_ready[1], (t % 4 == 0));
      end
      checks++;
      if (resp_valid[1] !== (t % 4 == 0 && t > 0)) begin
        errors++; $display("FAIL b2b_resp t=%0d got %b exp %b", t, resp_valid[1], (t % 4 == 0 && t > 0));
      end
      @(posedge CLK);
      #1;
      if (t % 4 == 0) begin
        req_addr[1] = 32'h40 + 32'(4 * (t / 4 + 1));
        req_data[1] = 32'hA0A00000 + 32'(t / 4 + 1);
      end
      @(negedge CLK);
    end
    req_valid[1] = 1'b0;
    repeat (5) @(negedge CLK);
    access(1, 1'b0, 32'h48, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hA0A00002} || lat !== 3) begin
      errors++; $display("FAIL b2b_readback got err=%b data=%h lat=%0d exp err=0 data=a0a00002 lat=3", e, d, lat);
    end
    access(1, 1'b0, 32'h50, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hA0A00004}) begin
      errors++; $display("FAIL b2b_last_store got err=%b data=%h exp err=0 data=a0a00004", e, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; int seen;
    access(0, 1'b1, 32'h20, SZ_WORD, 1'b0, 32'h11223344, d, e, lat);
    @(negedge CLK);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_size[0] = SZ_WORD; req_data[0] = 32'hAABBCCDD;
    @(posedge CLK);
    @(negedge CLK);
    req_valid[0] = 1'b0;
    checks++;
    if (req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL wait_not_ready got %b exp 0", req_ready[0]);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({req_ready[0], resp_valid[0]} !== 2'b10) begin
      errors++; $display("FAIL reset_mid_ctrl got rdy=%b vld=%b exp rdy=1 vld=0", req_ready[0], resp_valid[0]);
    end
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid[0]) seen++;
      @(negedge CLK);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid_no_resp got %0d pulses exp 0", seen);
    end
    checks++;
    if ({u0.Mem[10'h023], u0.Mem[10'h022], u0.Mem[10'h021], u0.Mem[10'h020]} !== 32'h11223344) begin
      errors++; $display("FAIL reset_mid_mem got %h exp 11223344",
        {u0.Mem[10'h023], u0.Mem[10'h022], u0.Mem[10'h021], u0.Mem[10'h020]});
    end
    access(0, 1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h11223344} || lat !== 2) begin
      errors++; $display("FAIL reset_mid_reload got err=%b data=%h lat=%0d exp err=0 data=11223344 lat=2", e, d, lat);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] d; logic e; int lat;
    access(2, 1'b1, 32'h100, SZ_WORD, 1'b0, 32'hCAFEF00D, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'h0} || lat !== 1) begin
      errors++; $display("FAIL lat1_store got err=%b data=%h lat=%0d exp err=0 data=0 lat=1", e, d, lat);
    end
    access(2, 1'b0, 32'h102, SZ_HALF, 1'b0, 32'h0, d, e, lat);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFCAFE} || lat !== 1) begin
      errors++; $display("FAIL lat1_load got err=%b data=%h lat=%0d exp err=0 data=ffffcafe lat=1", e, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_partial_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
